// File: rtl/decode_pkg.sv
// decode_pkg: instruction field map and stage storage types
// shared by the decode stage and its field extractor.
package decode_pkg;

  localparam int INSTR_W = 32;
  localparam int REG_W   = 4;
  localparam int PC_W_DEF = 27;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 28;
  localparam int ALUOP_MSB = 27;
  localparam int ALUOP_LSB = 24;
  localparam int CALU_MSB  = 23;
  localparam int CALU_LSB  = 8;
  localparam int C16_MSB   = 27;
  localparam int C16_LSB   = 12;
  localparam int C27_MSB   = 27;
  localparam int C27_LSB   = 1;
  localparam int AREG_MSB  = 11;
  localparam int AREG_LSB  = 8;
  localparam int BREG_MSB  = 7;
  localparam int BREG_LSB  = 4;
  localparam int DREG_MSB  = 3;
  localparam int DREG_LSB  = 0;
  localparam int HE_BIT    = 8;
  localparam int OE_BIT    = 0;
  localparam int SIG_BIT   = 0;

  // One buffered entry at the default PC width; the stage
  // declares the same shape locally for other PC_W values.
  typedef struct packed {
    logic                valid;
    logic [INSTR_W-1:0]  instr;
    logic [PC_W_DEF-1:0] pc;
  } dec_entry_t;

endpackage

// File: rtl/decode_fields.sv
// decode_fields: combinational field extraction from a
// raw instruction word. DATA_W must be at least 16.
module decode_fields
  import decode_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output logic [3:0]         instr_op,
  output logic [3:0]         alu_op,
  output logic [DATA_W-1:0]  const_alu,
  output logic [DATA_W-1:0]  const16,
  output logic [15:0]        const16u,
  output logic [26:0]        const27,
  output logic [REG_W-1:0]   areg,
  output logic [REG_W-1:0]   breg,
  output logic [REG_W-1:0]   dreg,
  output logic               he,
  output logic               oe,
  output logic               sig
);

  assign instr_op  = instr[OP_MSB:OP_LSB];
  assign alu_op    = instr[ALUOP_MSB:ALUOP_LSB];
  // Signed size casts replicate bit 15 into the upper bits.
  assign const_alu =
    DATA_W'($signed(instr[CALU_MSB:CALU_LSB]));
  assign const16   =
    DATA_W'($signed(instr[C16_MSB:C16_LSB]));
  assign const16u  = instr[C16_MSB:C16_LSB];
  assign const27   = instr[C27_MSB:C27_LSB];
  assign areg      = instr[AREG_MSB:AREG_LSB];
  assign breg      = instr[BREG_MSB:BREG_LSB];
  assign dreg      = instr[DREG_MSB:DREG_LSB];
  assign he        = instr[HE_BIT];
  assign oe        = instr[OE_BIT];
  assign sig       = instr[SIG_BIT];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered decode behind a 2-entry skid buffer.
// Optional DECODE_PERF_CNT_EN adds an output-accept counter.
module decode_stage
  import decode_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 27
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [3:0]         instr_op,
  output logic [3:0]         alu_op,
  output logic [DATA_W-1:0]  const_alu,
  output logic [DATA_W-1:0]  const16,
  output logic [15:0]        const16u,
  output logic [26:0]        const27,
  output logic [REG_W-1:0]   areg,
  output logic [REG_W-1:0]   breg,
  output logic [REG_W-1:0]   dreg,
  output logic               he,
  output logic               oe,
  output logic               sig,
  output logic [31:0]        perf_cnt
);

  typedef struct packed {
    logic               valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } entry_t;

  entry_t m_q, m_d;
  entry_t s_q, s_d;
  entry_t in_e;
  logic   in_acc;
  logic   out_acc;

  // in_ready comes straight from a flop: no comb path to fetch.
  assign in_ready  = !s_q.valid;
  assign out_valid = m_q.valid;
  assign out_pc    = m_q.pc;
  assign in_acc    = in_valid && in_ready && !flush;
  assign out_acc   = m_q.valid && out_ready;
  assign in_e      = '{valid: 1'b1,
                       instr: in_instr,
                       pc:    in_pc};

  // Main/skid next state; S is only ever valid while M is.
  always_comb begin
    m_d = m_q;
    s_d = s_q;
    if (flush) begin
      m_d.valid = 1'b0;
      s_d.valid = 1'b0;
    end else if (!m_q.valid) begin
      if (in_acc) m_d = in_e;
    end else if (out_acc) begin
      if (s_q.valid) begin
        m_d       = s_q;
        s_d.valid = 1'b0;
      end else if (in_acc) begin
        m_d = in_e;
      end else begin
        m_d.valid = 1'b0;
      end
    end else if (in_acc) begin
      s_d = in_e;
    end
  end

  // Entry registers; reset drops both entries at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q <= '0;
      s_q <= '0;
    end else begin
      m_q <= m_d;
      s_q <= s_d;
    end
  end

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Count consumed outputs, wrapping naturally; flush keeps it.
  always_comb begin
    perf_d = perf_q + 32'(out_acc);
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_cnt = perf_q;
`else
  assign perf_cnt = '0;
`endif

  decode_fields #(
    .DATA_W (DATA_W)
  ) u_fields (
    .instr     (m_q.instr),
    .instr_op  (instr_op),
    .alu_op    (alu_op),
    .const_alu (const_alu),
    .const16   (const16),
    .const16u  (const16u),
    .const27   (const27),
    .areg      (areg),
    .breg      (breg),
    .dreg      (dreg),
    .he        (he),
    .oe        (oe),
    .sig       (sig)
  );

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed checks of decode_stage handshake,
// field map, flush, a 24-bit constant build and perf counter.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [26:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [26:0] out_pc;
  logic [3:0]  instr_op, alu_op;
  logic [31:0] const_alu, const16;
  logic [15:0] const16u;
  logic [26:0] const27;
  logic [3:0]  areg, breg, dreg;
  logic        he, oe, sig;
  logic [31:0] perf_cnt;

  logic        w_in_ready, w_out_valid;
  logic [26:0] w_out_pc;
  logic [3:0]  w_instr_op, w_alu_op;
  logic [23:0] w_const_alu, w_const16;
  logic [15:0] w_const16u;
  logic [26:0] w_const27;
  logic [3:0]  w_areg, w_breg, w_dreg;
  logic        w_he, w_oe, w_sig;
  logic [31:0] w_perf_cnt;

  int n_run = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_stage #(.DATA_W(32), .PC_W(27)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .instr_op(instr_op),
    .alu_op(alu_op), .const_alu(const_alu),
    .const16(const16), .const16u(const16u),
    .const27(const27), .areg(areg), .breg(breg),
    .dreg(dreg), .he(he), .oe(oe), .sig(sig),
    .perf_cnt(perf_cnt)
  );

  decode_stage #(.DATA_W(24), .PC_W(27)) dut24 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(w_in_ready),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(w_out_valid), .out_ready(out_ready),
    .out_pc(w_out_pc), .instr_op(w_instr_op),
    .alu_op(w_alu_op), .const_alu(w_const_alu),
    .const16(w_const16), .const16u(w_const16u),
    .const27(w_const27), .areg(w_areg), .breg(w_breg),
    .dreg(w_dreg), .he(w_he), .oe(w_oe), .sig(w_sig),
    .perf_cnt(w_perf_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    step(); step();
    reset = 1'b0;
    #1;
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_out_valid: got %b want 0", out_valid);
    end
    n_run++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_in_ready: got %b want 1", in_ready);
    end
    n_run++;
    if (const_alu !== 32'h0 || out_pc !== 27'h0) begin
      n_fail++;
      $display("FAIL rst_fields: got %h/%h want 0/0",
               const_alu, out_pc);
    end
    n_run++;
    if (perf_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_perf: got %h want 0", perf_cnt);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    in_valid = 1'b1; out_ready = 1'b1;
    in_instr = 32'h3A12_3456; in_pc = 27'h100;
    step();
    in_valid = 1'b0;
    n_run++;
    if (out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_valid: got %b want 1", out_valid);
    end
    n_run++;
    if (instr_op !== 4'h3 || alu_op !== 4'hA) begin
      n_fail++;
      $display("FAIL basic_ops: got %h/%h want 3/a",
               instr_op, alu_op);
    end
    n_run++;
    if (const_alu !== 32'h0000_1234) begin
      n_fail++;
      $display("FAIL basic_const_alu: got %h want 00001234",
               const_alu);
    end
    n_run++;
    if (const16 !== 32'hFFFF_A123) begin
      n_fail++;
      $display("FAIL basic_const16: got %h want ffffa123",
               const16);
    end
    n_run++;
    if (const16u !== 16'hA123) begin
      n_fail++;
      $display("FAIL basic_const16u: got %h want a123",
               const16u);
    end
    n_run++;
    if (const27 !== 27'h509_1A2B) begin
      n_fail++;
      $display("FAIL basic_const27: got %h want 5091a2b",
               const27);
    end
    n_run++;
    if (areg !== 4'h4 || breg !== 4'h5 || dreg !== 4'h6) begin
      n_fail++;
      $display("FAIL basic_regs: got %h/%h/%h want 4/5/6",
               areg, breg, dreg);
    end
    n_run++;
    if (he !== 1'b0 || oe !== 1'b0 || sig !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_bits: got %b%b%b want 000",
               he, oe, sig);
    end
    n_run++;
    if (out_pc !== 27'h100) begin
      n_fail++;
      $display("FAIL basic_pc: got %h want 100", out_pc);
    end
    n_run++;
    if (w_const_alu !== 24'h00_1234) begin
      n_fail++;
      $display("FAIL basic_w24: got %h want 001234",
               w_const_alu);
    end
    step();
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain: got %b want 0", out_valid);
    end
    in_valid = 1'b1; in_instr = 32'h0000_0101;
    in_pc = 27'h101;
    step();
    in_valid = 1'b0;
    n_run++;
    if (he !== 1'b1 || oe !== 1'b1 || sig !== 1'b1) begin
      n_fail++;
      $display("FAIL bits_set: got %b%b%b want 111",
               he, oe, sig);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [26:0] got [4];
    logic [2:0]  rdy;
    int          ng;
    ng = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rdy[i]   = in_ready;
      in_valid = 1'b1;
      in_instr = 32'h1000_0000 + i;
      in_pc    = 27'h11 + 27'(i);
      step();
    end
    in_valid = 1'b0;
    n_run++;
    if (rdy !== 3'b011) begin
      n_fail++;
      $display("FAIL bp_in_ready: got %b want 011", rdy);
    end
    n_run++;
    if (out_pc !== 27'h11) begin
      n_fail++;
      $display("FAIL bp_hold: got %h want 11", out_pc);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (out_valid && ng < 4) begin
        got[ng] = out_pc;
        ng++;
      end
      step();
    end
    n_run++;
    if (ng !== 2) begin
      n_fail++;
      $display("FAIL bp_count: got %0d want 2", ng);
    end
    n_run++;
    if (got[0] !== 27'h11 || got[1] !== 27'h12) begin
      n_fail++;
      $display("FAIL bp_order: got %h,%h want 11,12",
               got[0], got[1]);
    end
  endtask

  task automatic test_streaming();
    int bad;
    bad = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_pc    = 27'h1000 + 27'(i);
      in_instr = 32'(i);
      step();
      if (!in_ready || !out_valid ||
          out_pc !== 27'h1000 + 27'(i))
        bad++;
    end
    in_valid = 1'b0;
    step();
    n_run++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL stream: got %0d bad cycles want 0", bad);
    end
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drain: got %b want 0", out_valid);
    end
  endtask

  task automatic test_flush();
    int seen;
    seen = 0;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_pc = 27'h21; step();
    in_pc = 27'h22; step();
    n_run++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_full: got %b want 0", in_ready);
    end
    in_pc = 27'h23; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fl_clear: got v%b r%b want v0 r1",
               out_valid, in_ready);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (out_valid) seen++;
      step();
    end
    n_run++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL fl_ghost: got %0d outputs want 0", seen);
    end
    in_valid = 1'b1; in_pc = 27'h24; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fl_drop: got %b want 0", out_valid);
    end
  endtask

  task automatic test_data_w24();
    in_valid = 1'b1; out_ready = 1'b1;
    in_instr = 32'h0080_0000; in_pc = 27'h40;
    step();
    in_valid = 1'b0;
    n_run++;
    if (w_const_alu !== 24'hFF_8000) begin
      n_fail++;
      $display("FAIL w24_sext: got %h want ff8000",
               w_const_alu);
    end
    n_run++;
    if (const_alu !== 32'hFFFF_8000) begin
      n_fail++;
      $display("FAIL w32_sext: got %h want ffff8000",
               const_alu);
    end
    step();
  endtask

  task automatic test_perf();
`ifdef DECODE_PERF_CNT_EN
    force dut.perf_q = 32'hFFFF_FFFF;
    #1;
    release dut.perf_q;
    #1;
    n_run++;
    if (perf_cnt !== 32'hFFFF_FFFF) begin
      n_fail++;
      $display("FAIL perf_preload: got %h want ffffffff",
               perf_cnt);
    end
    in_valid = 1'b1; out_ready = 1'b1; in_pc = 27'h50;
    step();
    in_valid = 1'b0;
    step();
    n_run++;
    if (perf_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL perf_wrap: got %h want 0", perf_cnt);
    end
`else
    n_run++;
    if (perf_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL perf_tied: got %h want 0", perf_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 27'h31; step();
    in_pc = 27'h32; step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    n_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_state: got v%b r%b want v0 r1",
               out_valid, in_ready);
    end
    n_run++;
    if (perf_cnt !== 32'h0) begin
      n_fail++;
      $display("FAIL rmid_perf: got %h want 0", perf_cnt);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
    n_run++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_after: got %b want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_streaming();
    test_flush();
    test_data_w24();
    test_perf();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
